// File: rtl/oled_pkg.sv
// Shared types and command constants for the OLED text feeder.
package oled_pkg;

  typedef enum logic [2:0] {
    INIT_FUNC,
    INIT_DISP,
    INIT_CLEAR,
    INIT_ENTRY,
    INIT_POWER,
    IDLE,
    SET_ADDR,
    SEND_CHAR
  } state_t;

  localparam logic [8:0] CMD_FUNC_SET = 9'h038;
  localparam logic [8:0] CMD_DISP_ON  = 9'h00C;
  localparam logic [8:0] CMD_CLEAR    = 9'h001;
  localparam logic [8:0] CMD_ENTRY    = 9'h006;
  localparam logic [8:0] CMD_PWR_CHAR = 9'h017;

  localparam int         RS_BIT     = 8;
  localparam logic [7:0] CMD_DDRAM  = 8'h80;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  function automatic logic [8:0] ddram_word(input logic [7:0] base);
    return {1'b0, CMD_DDRAM | base};
  endfunction

  function automatic logic [8:0] char_word(input logic [7:0] ch);
    logic [8:0] w;
    w         = {1'b0, ch};
    w[RS_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/oled_text_buf.sv
// 2xCOLS character store with one write port, a combinational read port and,
// under OLED_TEXT_FEEDER_DIRTY_EN, per-row dirty tracking.
module oled_text_buf
  import oled_pkg::*;
#(
  parameter int COLS = 16,
  parameter int AW   = $clog2(2*COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
`ifdef OLED_TEXT_FEEDER_DIRTY_EN
  ,
  input  logic          clr_en,
  input  logic          clr_row,
  output logic [1:0]    dirty
`endif
);

  localparam int        DEPTH   = 2*COLS;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic       wr_ok;

  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CHAR_SPACE;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef OLED_TEXT_FEEDER_DIRTY_EN
  localparam logic [AW:0] COLS_W = (AW+1)'(COLS);

  logic       wr_row;
  logic [1:0] dirty_nxt;

  assign wr_row = ({1'b0, wr_addr} >= COLS_W);

  // A host write lands after the clear so it survives a same-cycle collision.
  always_comb begin
    dirty_nxt = dirty;
    if (clr_en) dirty_nxt[clr_row] = 1'b0;
    if (wr_ok)  dirty_nxt[wr_row]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dirty <= 2'b11;
    else        dirty <= dirty_nxt;
  end
`endif

endmodule

// File: rtl/oled_text_feeder.sv
// Init sequencer and row streamer feeding the 16x2 OLED bus driver.
// Optional OLED_TEXT_FEEDER_DIRTY_EN: refresh only rows written since last pass.
module oled_text_feeder
  import oled_pkg::*;
#(
  parameter int         COLS      = 16,
  parameter logic [7:0] ROW1_BASE = 8'h40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(2*COLS)-1:0]  wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       cmd_ready,
  output logic [8:0]                 cmd,
  output logic                       cmd_strobe,
  output logic                       cmd_wait,
  output logic                       init_done
);

  localparam int            AW       = $clog2(2*COLS);
  localparam int            CW       = $clog2(COLS);
  localparam logic [AW-1:0] ROW1_OFS = AW'(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);

  state_t        state, state_nxt;
  logic          row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic          issue_ok, issue, issue_wait, init_done_nxt;
  logic [8:0]    issue_word;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          clr_en;
`ifdef OLED_TEXT_FEEDER_DIRTY_EN
  logic [1:0]    dirty;
`endif

  // The strobe term blocks a second issue while the driver has not yet dropped ready.
  assign issue_ok = cmd_ready && !cmd_strobe;
  assign rd_addr  = row ? (ROW1_OFS + AW'(col)) : AW'(col);

  oled_text_buf #(.COLS(COLS), .AW(AW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef OLED_TEXT_FEEDER_DIRTY_EN
    ,
    .clr_en  (clr_en),
    .clr_row (row),
    .dirty   (dirty)
`endif
  );

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    col_nxt       = col;
    issue         = 1'b0;
    issue_word    = '0;
    issue_wait    = 1'b0;
    init_done_nxt = init_done;
    clr_en        = 1'b0;
    case (state)
      INIT_FUNC: if (issue_ok) begin
        issue = 1'b1; issue_word = CMD_FUNC_SET; issue_wait = 1'b1; state_nxt = INIT_DISP;
      end
      INIT_DISP: if (issue_ok) begin
        issue = 1'b1; issue_word = CMD_DISP_ON; issue_wait = 1'b1; state_nxt = INIT_CLEAR;
      end
      INIT_CLEAR: if (issue_ok) begin
        issue = 1'b1; issue_word = CMD_CLEAR; issue_wait = 1'b1; state_nxt = INIT_ENTRY;
      end
      INIT_ENTRY: if (issue_ok) begin
        issue = 1'b1; issue_word = CMD_ENTRY; issue_wait = 1'b1; state_nxt = INIT_POWER;
      end
      INIT_POWER: if (issue_ok) begin
        issue = 1'b1; issue_word = CMD_PWR_CHAR; issue_wait = 1'b1;
        state_nxt = IDLE; init_done_nxt = 1'b1;
      end
      IDLE: begin
`ifdef OLED_TEXT_FEEDER_DIRTY_EN
        if (dirty[0]) begin
          row_nxt = 1'b0; col_nxt = '0; state_nxt = SET_ADDR;
        end else if (dirty[1]) begin
          row_nxt = 1'b1; col_nxt = '0; state_nxt = SET_ADDR;
        end
`else
        row_nxt   = ~row;
        col_nxt   = '0;
        state_nxt = SET_ADDR;
`endif
      end
      SET_ADDR: if (issue_ok) begin
        issue      = 1'b1;
        issue_word = ddram_word(row ? ROW1_BASE : 8'h00);
        issue_wait = 1'b1;
        clr_en     = 1'b1;
        state_nxt  = SEND_CHAR;
      end
      SEND_CHAR: if (issue_ok) begin
        issue      = 1'b1;
        issue_word = char_word(rd_data);
        col_nxt    = col + CW'(1);
        if (col == LAST_COL) state_nxt = IDLE;
      end
      default: state_nxt = INIT_FUNC;
    endcase
  end

  // Row resets to 1 so the free-running alternation starts with row 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT_FUNC;
      row        <= 1'b1;
      col        <= '0;
      cmd        <= '0;
      cmd_strobe <= 1'b0;
      cmd_wait   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      cmd_strobe <= issue;
      init_done  <= init_done_nxt;
      if (issue) begin
        cmd      <= issue_word;
        cmd_wait <= issue_wait;
      end
    end
  end

endmodule

// File: tb/tb_oled_text_feeder.sv
// Scoreboard bench for oled_text_feeder with a ready/busy driver model.
module tb_oled_text_feeder;
  import oled_pkg::*;

  localparam int COLS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_ready;
  logic [8:0] cmd;
  logic       cmd_strobe;
  logic       cmd_wait;
  logic       init_done;

  always #5 clk = ~clk;

  oled_text_feeder #(.COLS(COLS), .ROW1_BASE(8'h40)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .cmd_strobe (cmd_strobe),
    .cmd_wait   (cmd_wait),
    .init_done  (init_done)
  );

  // Driver model: ready drops the cycle after a strobe and returns 3 cycles later.
  int   busy_cnt = 0;
  logic hold     = 1'b0;
  always @(posedge clk) begin
    if (cmd_strobe === 1'b1) busy_cnt <= 3;
    else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
  end
  assign cmd_ready = (busy_cnt == 0) && !hold;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [9:0] exp;
    bit         is_char;
    int         addr;
  } item_t;

  item_t      sbq[$];
  logic [7:0] tb_buf [2*COLS];
  bit         auto_refill = 0;
  bit         next_row    = 0;
  bit         col7_hit    = 0;
  int         n_strobes   = 0;

  task automatic clear_model();
    for (int i = 0; i < 2*COLS; i++) tb_buf[i] = 8'h20;
  endtask

  task automatic push_ctrl(input logic [8:0] w);
    item_t it;
    it.exp = {1'b1, w}; it.is_char = 0; it.addr = 0;
    sbq.push_back(it);
  endtask

  task automatic push_init();
    push_ctrl(9'h038); push_ctrl(9'h00C); push_ctrl(9'h001);
    push_ctrl(9'h006); push_ctrl(9'h017);
  endtask

  task automatic push_pass(input bit r);
    item_t it;
    push_ctrl(r ? 9'h0C0 : 9'h080);
    for (int c = 0; c < COLS; c++) begin
      it.exp = '0; it.is_char = 1; it.addr = (r ? COLS : 0) + c;
      sbq.push_back(it);
    end
  endtask

  // Character expectations resolve at compare time; writes only happen while no issue can occur.
  always @(negedge clk) begin : monitor
    item_t      it;
    logic [9:0] e;
    if (reset === 1'b1 && cmd_strobe === 1'b1) begin
      n_strobes++;
      if (sbq.size() == 0) begin
        check("sb_underflow", {22'd0, cmd_wait, cmd}, 32'hFFFF_FFFF);
      end else begin
        it = sbq.pop_front();
        e  = it.is_char ? {2'b01, tb_buf[it.addr]} : it.exp;
        check(it.is_char ? "char_word" : "ctrl_word", {22'd0, cmd_wait, cmd}, {22'd0, e});
        if (it.is_char && (it.addr % COLS) == 7) col7_hit = 1;
      end
      if (auto_refill && sbq.size() < 2*COLS + 2) begin
        push_pass(next_row);
        next_row = ~next_row;
      end
    end
  end

  task automatic host_write(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a[4:0]; wr_data = d; tb_buf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 200 && init_done !== 1'b1; i++) @(negedge clk);
    #1 check("init_done_set", {31'd0, init_done}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 1500 && sbq.size() != 0; i++) @(negedge clk);
    check(tag, sbq.size(), 0);
  endtask

  task automatic check_silence(input string tag, input int cycles);
    int s0;
    s0 = n_strobes;
    repeat (cycles) @(negedge clk);
    #1 check(tag, n_strobes - s0, 0);
  endtask

  task automatic wait_strobes(input int n);
    for (int i = 0; i < 2000 && n_strobes < n; i++) @(negedge clk);
    check("strobe_progress", {31'd0, n_strobes >= n}, 32'd1);
  endtask

  initial begin
    int s0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clear_model();
    push_init(); push_pass(0); push_pass(1);
`ifndef OLED_TEXT_FEEDER_DIRTY_EN
    auto_refill = 1; next_row = 0;
`endif
    #1;
    check("rst_cmd",       {23'd0, cmd}, 32'd0);
    check("rst_strobe",    {31'd0, cmd_strobe}, 32'd0);
    check("rst_wait",      {31'd0, cmd_wait}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_init();

`ifdef OLED_TEXT_FEEDER_DIRTY_EN
    wait_drain("initial_refresh_drain");
    check_silence("idle_after_refresh", 100);

    push_pass(1);
    host_write(17, 8'h41);
    wait_drain("row1_dirty_drain");
    check_silence("idle_after_row1", 100);

    // Second write lands in the SET_ADDR issue cycle: the row must be refreshed twice.
    push_pass(0); push_pass(0);
    host_write(0, 8'h30);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h5A; tb_buf[3] = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("clear_collision_drain");
    check_silence("idle_after_collision", 100);

    push_pass(0);
    host_write(5, 8'h35);
`else
    wait_strobes(12);
    @(negedge clk);
    hold = 1'b1;
    @(posedge clk); #1;
    s0 = n_strobes;
    @(negedge clk);
    host_write(20, 8'h7E);
    repeat (48) @(negedge clk);
    @(posedge clk); #1;
    check("hold_no_strobe", n_strobes - s0, 0);
    @(negedge clk);
    hold = 1'b0;

    s0 = n_strobes;
    repeat (200) @(negedge clk);
    #1 check("continuous_refresh", {31'd0, (n_strobes - s0) >= 30}, 32'd1);
`endif

    col7_hit = 0;
    for (int i = 0; i < 600 && !col7_hit; i++) begin
      @(negedge clk); #1;
    end
    check("col7_seen", {31'd0, col7_hit}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_cmd",       {23'd0, cmd}, 32'd0);
    check("async_strobe",    {31'd0, cmd_strobe}, 32'd0);
    check("async_wait",      {31'd0, cmd_wait}, 32'd0);
    check("async_init_done", {31'd0, init_done}, 32'd0);
    auto_refill = 0;
    sbq.delete();
    clear_model();
    push_init(); push_pass(0); push_pass(1);
`ifndef OLED_TEXT_FEEDER_DIRTY_EN
    auto_refill = 1; next_row = 0;
`endif
    repeat (3) @(negedge clk);
    s0 = n_strobes;
    reset = 1'b1;
    wait_init();
`ifdef OLED_TEXT_FEEDER_DIRTY_EN
    wait_drain("post_reset_drain");
    check_silence("post_reset_idle", 60);
`else
    wait_strobes(s0 + 45);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_text_feeder.md
Name: oled_text_feeder

Overview:
- Upstream command source for the 16x2 character OLED bus driver.
- Holds a 2x16 character buffer written by the host. After reset it issues the panel init sequence, then streams buffer contents to the driver as command words.
- Emits 9-bit words {rs, data} using the driver's ready/strobe/wait_for_busy handshake.

Parameters:
- COLS, 16, characters per row (two rows fixed). Buffer depth is 2*COLS; the write address is 5 bits at the default.
- ROW1_BASE, 8'h40, DDRAM base address of row 1 (row 0 base is 8'h00).

Ports:
- clk  input  1  system clock (same clock as the driver).
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  host write strobe, one character per cycle.
- wr_addr  input  5  buffer index: 0..15 is row 0, 16..31 is row 1; values >= 2*COLS are ignored.
- wr_data  input  8  character code.
- cmd_ready  input  1  driver idle/ready.
- cmd  output  9  {rs, byte} to driver.
- cmd_strobe  output  1  one-cycle command pulse.
- cmd_wait  output  1  driver must poll busy after this command.
- init_done  output  1  high once the init sequence has completed.

Behaviour:
- Reset (async assert, sync release):
  - cmd=0, cmd_strobe=0, cmd_wait=0, init_done=0, state=INIT_FUNC.
  - Buffer cleared to 8'h20 (space); both row-dirty bits set.
- Handshake:
  - A command issues only in a cycle where cmd_ready=1 and cmd_strobe=0. The driver drops ready one cycle after strobe, so this guard prevents double issue.
  - When a command issues, cmd/cmd_wait/cmd_strobe are registered together. cmd_strobe is high exactly one cycle; cmd/cmd_wait hold until the next issue.
- Init states, each issuing one word with cmd_wait=1, then advancing:
  - INIT_FUNC 9'h038 -> INIT_DISP
  - INIT_DISP 9'h00C -> INIT_CLEAR
  - INIT_CLEAR 9'h001 -> INIT_ENTRY
  - INIT_ENTRY 9'h006 -> INIT_POWER
  - INIT_POWER 9'h017 (character mode, power on) -> IDLE, and set init_done=1.
- IDLE: selects a row to refresh (see Optional Feature). Priority is row 0 then row 1. Goes to SET_ADDR with row latched and col=0.
- SET_ADDR:
  - Issues {1'b0, 1'b1, base[6:0]} with cmd_wait=1; base is 0 or ROW1_BASE. Goes to SEND_CHAR.
  - Clears the selected row's dirty bit in the issue cycle.
- SEND_CHAR:
  - Issues {1'b1, buf[row*COLS+col]} with cmd_wait=0, reading the buffer combinationally at issue time.
  - col increments. At col==COLS-1, go to IDLE.
- Host writes:
  - Accepted in any state, including during init, and never stalled.
  - Set the target row's dirty bit. If a write and the dirty-clear hit the same row in the same cycle, the write wins and the bit stays set.
  - A write to a character already sent this pass appears on the next pass.
- Reset mid-operation: all state is abandoned immediately; on release the init sequence restarts from INIT_FUNC.

Optional Feature:
- Macro OLED_TEXT_FEEDER_DIRTY_EN.
- Defined: IDLE waits until some dirty bit is set and refreshes only dirty rows. With no writes after the initial refresh, cmd_strobe stays 0.
- Undefined: dirty bits are absent. IDLE alternates row 0 and row 1 unconditionally, giving a continuous refresh with no idle gaps beyond the handshake.

Decomposition:
- Shared package oled_pkg holds:
  - State enum: INIT_FUNC, INIT_DISP, INIT_CLEAR, INIT_ENTRY, INIT_POWER, IDLE, SET_ADDR, SEND_CHAR.
  - Init command constants: CMD_FUNC_SET=9'h038, CMD_DISP_ON=9'h00C, CMD_CLEAR=9'h001, CMD_ENTRY=9'h006, CMD_PWR_CHAR=9'h017.
  - RS bit position 8 and CMD_DDRAM=8'h80.
- One natural sub-module, oled_text_buf: the 2xCOLS register array with a write port, a combinational read port, and per-row dirty logic.

Test Plan:
- Release reset with a ready-model driver (ready drops one cycle after strobe, returns after 3 cycles) -> strobes carry 038,00C,001,006,017, all with cmd_wait=1; then init_done=1; then 080 followed by sixteen 120 words with wait=0; then 0C0 followed by sixteen 120 words.
- Hold cmd_ready=0 for 50 cycles mid-sequence -> zero strobes; sequence resumes in order with no word skipped or duplicated.
- With DIRTY_EN: write addr 17 = 8'h41 after the initial refresh -> exactly 0C0, 120, 141, then fourteen 120 words; then silence.
- Write addr 3 = 8'h5A in the same cycle SET_ADDR clears row 0's dirty bit -> row 0 is refreshed a second time and the second pass contains 15A at position 3.
- Without DIRTY_EN: no writes for 200 cycles -> row 0 and row 1 passes alternate continuously.
- Assert reset during SEND_CHAR col 7 -> outputs drop to 0 asynchronously; after release, the first strobe is 038.
